// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared defaults, widths and helpers for the SRAM bank controller
package sram_ctrl_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_CNT_W  = 16;

  typedef struct packed {
    logic valid;
    logic err;
    logic coll;
  } rd_flags_t;

  function automatic int bank_w_of(input int num_banks);
    return (num_banks <= 1) ? 1 : $clog2(num_banks);
  endfunction

  // One byte lane of a masked merge: the new byte wins where the mask bit is set.
  function automatic logic [7:0] merge_byte(input logic mask, input logic [7:0] new_byte,
                                            input logic [7:0] old_byte);
    return mask ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/sram_rd_hold.sv
// rtl/sram_rd_hold.sv - read pipeline, collision bypass merge and read-data hold register
module sram_rd_hold
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = bank_w_of(NUM_BANKS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rd_req,
  input  logic                          rd_ok,
  input  logic [BANK_W-1:0]             rd_bank,
  input  logic                          coll,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [DATA_W/8-1:0]           wr_mask,
  input  logic [NUM_BANKS*DATA_W-1:0]   mem_dout1,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid
);

  localparam int NB = DATA_W / 8;

  rd_flags_t         flags_q;
  logic [BANK_W-1:0] bank_q;
  logic [DATA_W-1:0] byp_data_q;
  logic [NB-1:0]     byp_mask_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] macro_data;
  logic [DATA_W-1:0] merged;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q    <= '0;
      bank_q     <= '0;
      byp_data_q <= '0;
      byp_mask_q <= '0;
      hold_q     <= '0;
    end else begin
      flags_q.valid <= rd_req;
      flags_q.err   <= rd_req & ~rd_ok;
      flags_q.coll  <= coll;
      if (rd_req) bank_q <= rd_bank;
      if (coll) begin
        byp_data_q <= wr_data;
        byp_mask_q <= wr_mask;
      end
      if (flags_q.valid) hold_q <= merged;
    end
  end

  always_comb begin
    macro_data = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_q == BANK_W'(b)) macro_data = mem_dout1[b*DATA_W +: DATA_W];
    end
  end

  // An out-of-range read returns zero; otherwise bypassed bytes replace the macro bytes.
  always_comb begin
    merged = '0;
    if (!flags_q.err) begin
      for (int i = 0; i < NB; i++) begin
        merged[i*8 +: 8] = merge_byte(flags_q.coll & byp_mask_q[i],
                                      byp_data_q[i*8 +: 8], macro_data[i*8 +: 8]);
      end
    end
  end

  assign rd_valid = flags_q.valid;
  assign rd_data  = flags_q.valid ? merged : hold_q;

endmodule

// File: rtl/sram_bank_ctrl.sv
// rtl/sram_bank_ctrl.sv - bank decode, chip selects and error/collision tracking for 1rw1r SRAM macros
module sram_bank_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = bank_w_of(NUM_BANKS),
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_ni,
  input  logic                        rd_en,
  input  logic [BANK_W+ADDR_W-1:0]    rd_addr,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_valid,
  input  logic                        wr_en,
  input  logic [BANK_W+ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic [DATA_W/8-1:0]         wr_mask,
  output logic                        addr_err,
  output logic [CNT_W-1:0]            coll_cnt,
  output logic                        mem_clk,
  output logic [NUM_BANKS-1:0]        mem_csb0,
  output logic [NUM_BANKS-1:0]        mem_web0,
  output logic [DATA_W/8-1:0]         mem_wmask0,
  output logic [ADDR_W-1:0]           mem_addr0,
  output logic [DATA_W-1:0]           mem_din0,
  output logic [NUM_BANKS-1:0]        mem_csb1,
  output logic [ADDR_W-1:0]           mem_addr1,
  input  logic [NUM_BANKS*DATA_W-1:0] mem_dout1
);

  localparam int BANK_SPAN = 1 << BANK_W;
  // Bit b set when bank index b has a macro behind it.
  localparam logic [BANK_SPAN-1:0] BANK_OK = {BANK_SPAN{1'b1}} >> (BANK_SPAN - NUM_BANKS);

  logic [BANK_W-1:0] rd_bank;
  logic [BANK_W-1:0] wr_bank;
  logic              rd_ok;
  logic              wr_ok;
  logic              coll;
  logic              err_now;

  assign rd_bank = rd_addr[BANK_W+ADDR_W-1:ADDR_W];
  assign wr_bank = wr_addr[BANK_W+ADDR_W-1:ADDR_W];
  assign rd_ok   = BANK_OK[rd_bank];
  assign wr_ok   = BANK_OK[wr_bank];
  assign coll    = rd_en & wr_en & (rd_addr == wr_addr) & rd_ok;
  assign err_now = (rd_en & ~rd_ok) | (wr_en & ~wr_ok);

  assign mem_clk    = wb_clk_i;
  assign mem_addr0  = wr_addr[ADDR_W-1:0];
  assign mem_din0   = wr_data;
  assign mem_wmask0 = wr_mask;
  assign mem_addr1  = rd_addr[ADDR_W-1:0];

  // Selects are gated by reset directly so macros stay idle before the first edge.
  always_comb begin
    mem_csb0 = '1;
    mem_web0 = '1;
    mem_csb1 = '1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (wb_rst_ni && wr_en && wr_ok && wr_bank == BANK_W'(b)) begin
        mem_csb0[b] = 1'b0;
        mem_web0[b] = 1'b0;
      end
      if (wb_rst_ni && rd_en && rd_ok && rd_bank == BANK_W'(b)) begin
        mem_csb1[b] = 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      addr_err <= 1'b0;
      coll_cnt <= '0;
    end else begin
      if (err_now) addr_err <= 1'b1;
      if (coll && coll_cnt != '1) coll_cnt <= coll_cnt + CNT_W'(1);
    end
  end

  sram_rd_hold #(
    .DATA_W    (DATA_W),
    .NUM_BANKS (NUM_BANKS),
    .BANK_W    (BANK_W)
  ) u_rd_hold (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_ni),
    .rd_req    (rd_en),
    .rd_ok     (rd_ok),
    .rd_bank   (rd_bank),
    .coll      (coll),
    .wr_data   (wr_data),
    .wr_mask   (wr_mask),
    .mem_dout1 (mem_dout1),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid)
  );

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// tb/tb_sram_bank_ctrl.sv - directed vector bench for sram_bank_ctrl (4-bank and 3-bank instances)
module tb_sram_bank_ctrl;

  logic wb_clk_i = 1'b0;
  logic wb_rst_ni;
  always #5 wb_clk_i = ~wb_clk_i;

  logic        rd_en, wr_en, en_b;
  logic [9:0]  rd_addr, wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;

  logic [31:0]  rd_data_a, din0_a;
  logic         rd_valid_a, addr_err_a, mem_clk_a;
  logic [15:0]  coll_cnt_a;
  logic [3:0]   csb0_a, web0_a, csb1_a, wmask0_a;
  logic [7:0]   addr0_a, addr1_a;
  logic [127:0] dout1_a;
  logic [31:0]  dout_a [4];
  logic [31:0]  mem_a [4][256];

  logic [31:0]  rd_data_b, din0_b;
  logic         rd_valid_b, addr_err_b, mem_clk_b;
  logic [1:0]   coll_cnt_b;
  logic [2:0]   csb0_b, web0_b, csb1_b;
  logic [3:0]   wmask0_b;
  logic [7:0]   addr0_b, addr1_b;
  logic [95:0]  dout1_b;
  logic [31:0]  dout_b [3];
  logic [31:0]  mem_b [3][256];

  sram_bank_ctrl dut_a (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .addr_err(addr_err_a), .coll_cnt(coll_cnt_a), .mem_clk(mem_clk_a),
    .mem_csb0(csb0_a), .mem_web0(web0_a), .mem_wmask0(wmask0_a), .mem_addr0(addr0_a),
    .mem_din0(din0_a), .mem_csb1(csb1_a), .mem_addr1(addr1_a), .mem_dout1(dout1_a)
  );

  sram_bank_ctrl #(.NUM_BANKS(3), .CNT_W(2)) dut_b (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .rd_en(rd_en & en_b), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .wr_en(wr_en & en_b), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .addr_err(addr_err_b), .coll_cnt(coll_cnt_b), .mem_clk(mem_clk_b),
    .mem_csb0(csb0_b), .mem_web0(web0_b), .mem_wmask0(wmask0_b), .mem_addr0(addr0_b),
    .mem_din0(din0_b), .mem_csb1(csb1_b), .mem_addr1(addr1_b), .mem_dout1(dout1_b)
  );

  // Macro models: registered read port (old data on same-edge write), random when not read.
  always @(posedge wb_clk_i) begin
    for (int b = 0; b < 4; b++) dout_a[b] <= !csb1_a[b] ? mem_a[b][addr1_a] : $urandom();
    for (int b = 0; b < 4; b++)
      if (!csb0_a[b] && !web0_a[b])
        for (int k = 0; k < 4; k++)
          if (wmask0_a[k]) mem_a[b][addr0_a][k*8 +: 8] = din0_a[k*8 +: 8];
  end
  always @(posedge wb_clk_i) begin
    for (int b = 0; b < 3; b++) dout_b[b] <= !csb1_b[b] ? mem_b[b][addr1_b] : $urandom();
    for (int b = 0; b < 3; b++)
      if (!csb0_b[b] && !web0_b[b])
        for (int k = 0; k < 4; k++)
          if (wmask0_b[k]) mem_b[b][addr0_b][k*8 +: 8] = din0_b[k*8 +: 8];
  end
  assign dout1_a = {dout_a[3], dout_a[2], dout_a[1], dout_a[0]};
  assign dout1_b = {dout_b[2], dout_b[1], dout_b[0]};

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic re, input logic [9:0] ra, input logic we,
                       input logic [9:0] wa, input logic [31:0] wd, input logic [3:0] wm);
    rd_en = re; rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd; wr_mask = wm;
  endtask

  task automatic next_cycle();
    @(posedge wb_clk_i);
    #1;
  endtask

  typedef struct {
    logic        re;
    logic [9:0]  ra;
    logic        we;
    logic [9:0]  wa;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic [3:0]  e_csb0;
    logic [3:0]  e_csb1;
    logic        e_valid;
    logic [31:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic re, input logic [9:0] ra, input logic we,
                              input logic [9:0] wa, input logic [31:0] wd, input logic [3:0] wm,
                              input logic [3:0] c0, input logic [3:0] c1, input logic v,
                              input logic [31:0] d);
    vec_t r;
    r.re = re; r.ra = ra; r.we = we; r.wa = wa; r.wd = wd; r.wm = wm;
    r.e_csb0 = c0; r.e_csb1 = c1; r.e_valid = v; r.e_data = d;
    return r;
  endfunction

  vec_t vecs [18];
  logic [9:0]  pre_addr [6];
  logic [31:0] pre_data [6];

  initial begin
    pre_addr = '{10'h210, 10'h120, 10'h003, 10'h103, 10'h203, 10'h303};
    pre_data = '{32'h12345678, 32'hAABBCCDD, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    //            re  ra      we  wa      wd             wm       csb0     csb1     v  data
    vecs[0]  = mk(0, 10'h0,   1, 10'h005, 32'hDEADBEEF, 4'hF, 4'b1110, 4'b1111, 0, 32'h0);
    vecs[1]  = mk(1, 10'h005, 0, 10'h0,   32'h0,        4'h0, 4'b1111, 4'b1110, 0, 32'h0);
    vecs[2]  = mk(0, 10'h0,   0, 10'h0,   32'h0,        4'h0, 4'b1111, 4'b1111, 1, 32'hDEADBEEF);
    vecs[3]  = mk(1, 10'h210, 0, 10'h0,   32'h0,        4'h0, 4'b1111, 4'b1011, 0, 32'hDEADBEEF);
    vecs[4]  = mk(0, 10'h0,   0, 10'h0,   32'h0,        4'h0, 4'b1111, 4'b1111, 1, 32'h12345678);
    vecs[5]  = mk(0, 10'h0,   0, 10'h0,   32'h0,        4'h0, 4'b1111, 4'b1111, 0, 32'h12345678);
    vecs[6]  = mk(1, 10'h120, 1, 10'h120, 32'h11223344, 4'h5, 4'b1101, 4'b1101, 0, 32'h12345678);
    vecs[7]  = mk(0, 10'h0,   0, 10'h0,   32'h0,        4'h0, 4'b1111, 4'b1111, 1, 32'hAA22CC44);
    vecs[8]  = mk(1, 10'h003, 0, 10'h0,   32'h0,        4'h0, 4'b1111, 4'b1110, 0, 32'hAA22CC44);
    vecs[9]  = mk(1, 10'h103, 0, 10'h0,   32'h0,        4'h0, 4'b1111, 4'b1101, 1, 32'hA0A0A0A0);
    vecs[10] = mk(1, 10'h203, 0, 10'h0,   32'h0,        4'h0, 4'b1111, 4'b1011, 1, 32'hB1B1B1B1);
    vecs[11] = mk(1, 10'h303, 0, 10'h0,   32'h0,        4'h0, 4'b1111, 4'b0111, 1, 32'hC2C2C2C2);
    vecs[12] = mk(0, 10'h0,   0, 10'h0,   32'h0,        4'h0, 4'b1111, 4'b1111, 1, 32'hD3D3D3D3);
    vecs[13] = mk(0, 10'h0,   0, 10'h0,   32'h0,        4'h0, 4'b1111, 4'b1111, 0, 32'hD3D3D3D3);
    vecs[14] = mk(0, 10'h0,   1, 10'h207, 32'h5A5A5A5A, 4'hF, 4'b1011, 4'b1111, 0, 32'hD3D3D3D3);
    vecs[15] = mk(0, 10'h0,   1, 10'h207, 32'h0F0F0F0F, 4'hC, 4'b1011, 4'b1111, 0, 32'hD3D3D3D3);
    vecs[16] = mk(1, 10'h207, 0, 10'h0,   32'h0,        4'h0, 4'b1111, 4'b1011, 0, 32'hD3D3D3D3);
    vecs[17] = mk(0, 10'h0,   0, 10'h0,   32'h0,        4'h0, 4'b1111, 4'b1111, 1, 32'h0F0F5A5A);

    // Reset with requests active: selects must stay deasserted.
    wb_rst_ni = 1'b0;
    en_b = 1'b1;
    drive(1, 10'h005, 1, 10'h005, 32'h1, 4'hF);
    next_cycle();
    @(negedge wb_clk_i);
    chk("rst_csb0_a", csb0_a, 4'hF);
    chk("rst_web0_a", web0_a, 4'hF);
    chk("rst_csb1_a", csb1_a, 4'hF);
    chk("rst_csb0_b", csb0_b, 3'h7);
    chk("rst_valid_a", rd_valid_a, 1'b0);
    chk("rst_data_a", rd_data_a, 32'h0);
    chk("rst_err_a", addr_err_a, 1'b0);
    chk("rst_cnt_a", coll_cnt_a, 16'h0);
    chk("mem_clk_a", mem_clk_a, wb_clk_i);
    next_cycle();
    en_b = 1'b0;
    drive(0, 10'h0, 0, 10'h0, 32'h0, 4'h0);
    wb_rst_ni = 1'b1;
    next_cycle();

    for (int i = 0; i < 6; i++) begin
      drive(0, 10'h0, 1, pre_addr[i], pre_data[i], 4'hF);
      next_cycle();
    end
    drive(0, 10'h0, 0, 10'h0, 32'h0, 4'h0);
    next_cycle();

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].re, vecs[i].ra, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].wm);
      @(negedge wb_clk_i);
      chk($sformatf("vec%0d_csb0", i), csb0_a, vecs[i].e_csb0);
      chk($sformatf("vec%0d_web0", i), web0_a, vecs[i].e_csb0);
      chk($sformatf("vec%0d_csb1", i), csb1_a, vecs[i].e_csb1);
      chk($sformatf("vec%0d_valid", i), rd_valid_a, vecs[i].e_valid);
      chk($sformatf("vec%0d_data", i), rd_data_a, vecs[i].e_data);
      next_cycle();
    end
    chk("coll_cnt_a_after_table", coll_cnt_a, 16'd1);
    chk("addr_err_a_after_table", addr_err_a, 1'b0);

    // Hold: one read, then idle cycles with random macro outputs.
    drive(1, 10'h210, 0, 10'h0, 32'h0, 4'h0);
    next_cycle();
    drive(0, 10'h0, 0, 10'h0, 32'h0, 4'h0);
    chk("hold_first_valid", rd_valid_a, 1'b1);
    chk("hold_first_data", rd_data_a, 32'h12345678);
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      chk($sformatf("hold%0d_valid", i), rd_valid_a, 1'b0);
      chk($sformatf("hold%0d_data", i), rd_data_a, 32'h12345678);
    end

    // Full-mask collisions; the 2-bit counter of dut_b saturates at 3.
    en_b = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive(1, 10'h011, 1, 10'h011, 32'(k) * 32'h01010101, 4'hF);
      next_cycle();
      chk($sformatf("sat%0d_cnt_a", k), coll_cnt_a, 16'(1 + k));
      chk($sformatf("sat%0d_cnt_b", k), coll_cnt_b, (k > 3) ? 2'd3 : 2'(k));
      chk($sformatf("sat%0d_byp_a", k), rd_data_a, 32'(k) * 32'h01010101);
    end
    drive(0, 10'h0, 0, 10'h0, 32'h0, 4'h0);
    next_cycle();
    chk("err_b_before_oob", addr_err_b, 1'b0);

    // Out-of-range bank 3 on the 3-bank instance.
    drive(0, 10'h0, 1, 10'h310, 32'hCAFEF00D, 4'hF);
    @(negedge wb_clk_i);
    chk("oob_wr_csb0_b", csb0_b, 3'h7);
    chk("oob_wr_web0_b", web0_b, 3'h7);
    next_cycle();
    chk("oob_wr_err_b", addr_err_b, 1'b1);
    drive(1, 10'h303, 0, 10'h0, 32'h0, 4'h0);
    @(negedge wb_clk_i);
    chk("oob_rd_csb1_b", csb1_b, 3'h7);
    next_cycle();
    drive(0, 10'h0, 0, 10'h0, 32'h0, 4'h0);
    chk("oob_rd_valid_b", rd_valid_b, 1'b1);
    chk("oob_rd_data_b", rd_data_b, 32'h0);
    chk("oob_rd_data_a", rd_data_a, 32'hD3D3D3D3);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      chk($sformatf("oob_sticky%0d", i), addr_err_b, 1'b1);
    end
    chk("oob_err_a", addr_err_a, 1'b0);

    // Reset arriving in the cycle the read result is presented.
    drive(1, 10'h210, 0, 10'h0, 32'h0, 4'h0);
    next_cycle();
    chk("midrst_valid_before", rd_valid_a, 1'b1);
    drive(1, 10'h210, 1, 10'h210, 32'h55555555, 4'hF);
    wb_rst_ni = 1'b0;
    #1;
    chk("midrst_valid", rd_valid_a, 1'b0);
    chk("midrst_data", rd_data_a, 32'h0);
    chk("midrst_csb0", csb0_a, 4'hF);
    chk("midrst_csb1", csb1_a, 4'hF);
    chk("midrst_cnt_a", coll_cnt_a, 16'h0);
    chk("midrst_cnt_b", coll_cnt_b, 2'd0);
    chk("midrst_err_b", addr_err_b, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_bank_ctrl.md
Name: sram_bank_ctrl

Overview:
- Parametrised single-clock controller for NUM_BANKS sky130 1rw1r SRAM macros. Port 0 of each macro is the write port; port 1 is the read port.
- Decodes a flat address into a bank and a row.
- Gives a 1-cycle read with a valid strobe, plus output hold (rd_data keeps the last read value when idle).
- Forwards write data when a read and a write hit the same address in the same cycle, and flags out-of-range accesses.
- Sits between user_proj_example and the SRAM macros in user_project_wrapper; it replaces the hand-written read-hold logic there.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 8, row address width per macro.
- NUM_BANKS, 4, number of macros, 1..8; need not be a power of two.
- BANK_W, clog2(NUM_BANKS) (1 when NUM_BANKS=1), bank-select width; derived, do not override.
- CNT_W, 16, width of the collision counter.

Ports:
- wb_clk_i  in  1  single clock for the block and all macros.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- rd_en  in  1  read request.
- rd_addr  in  BANK_W+ADDR_W  read address; bank is the upper BANK_W bits.
- rd_data  out  DATA_W  read data, held between reads.
- rd_valid  out  1  pulse: rd_data carries a fresh read this cycle.
- wr_en  in  1  write request.
- wr_addr  in  BANK_W+ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_mask  in  DATA_W/8  byte-enable mask, 1 = write that byte.
- addr_err  out  1  sticky: an out-of-range bank was accessed; cleared only by reset.
- coll_cnt  out  CNT_W  saturating count of same-cycle read/write collisions.
- mem_clk  out  1  equals wb_clk_i.
- mem_csb0  out  NUM_BANKS  active-low chip select, write port.
- mem_web0  out  NUM_BANKS  active-low write enable, write port.
- mem_wmask0  out  DATA_W/8  write mask, shared by all banks.
- mem_addr0  out  ADDR_W  write row, shared.
- mem_din0  out  DATA_W  write data, shared.
- mem_csb1  out  NUM_BANKS  active-low chip select, read port.
- mem_addr1  out  ADDR_W  read row, shared.
- mem_dout1  in  NUM_BANKS*DATA_W  read data from each macro; bank b occupies bits [b*DATA_W +: DATA_W].

Behaviour:
- **Reset values.** rd_valid=0, rd_data=0 (hold register cleared), addr_err=0, coll_cnt=0, bypass registers cleared.
- **Chip selects under reset.** While wb_rst_ni=0, all mem_csb0, mem_web0 and mem_csb1 bits are forced to 1, combinationally.
- **Write decode (combinational, same cycle).** If wr_en=1 and the bank is < NUM_BANKS, only that bank's csb0 and web0 go to 0. addr0, din0 and wmask0 are passed straight through.
- **Read decode.** If rd_en=1 and the bank is in range, only that bank's csb1 goes to 0 and addr1 is set to the row.
- **Out-of-range access.** A bank >= NUM_BANKS selects no macro and sets addr_err at the next edge.
  - Such a read still pulses rd_valid at t+1, with rd_data = 0.
  - Such a write is dropped.
- **Read pipeline.** A read accepted at edge t registers the bank, the valid bit and the error bit; rd_valid=1 during cycle t+1.
- **Read data muxing.**
  - rd_data = merged macro data while rd_valid=1; otherwise rd_data = hold_q.
  - hold_q captures the merged data on every edge where rd_valid=1.
  - Net effect: rd_data is stable indefinitely after a read, with no glitch when rd_en drops.
- **Collision bypass.** Condition: rd_en & wr_en & (rd_addr == wr_addr) & bank in range, in the same cycle.
  - The macro port-1 output is undefined in this case, so the block registers wr_data and wr_mask.
  - In cycle t+1, bytes with mask=1 come from the registered wr_data; bytes with mask=0 come from mem_dout1.
  - coll_cnt increments by 1 and saturates at 2^CNT_W-1.
- **Write then read.** A write at t followed by a read of the same address at t+1 needs no bypass; the macro returns the new data.
- **Back-to-back reads.** A read every cycle gives rd_valid high continuously with no bubble.
- **Reset mid-read.** The pending read is discarded, rd_valid=0 immediately, and rd_data=0.

Decomposition:
- **sram_ctrl_pkg:** DATA_W/ADDR_W defaults, BANK_W derivation function, a byte-merge function (mask, new data, old data), and the CNT_W default.
- **sram_rd_hold sub-module:** the read-pipeline registers, the bypass registers, the byte merge, hold_q and the rd_data mux.
- **Top level:** address decode, chip-select generation, addr_err, coll_cnt.

Test Plan:
- **Write/read round trip.** Reset, then write 0xDEADBEEF to addr 0x0_05 with mask 0xF; next cycle read 0x0_05 → rd_valid pulses 1 cycle later with rd_data=0xDEADBEEF; only mem_csb0[0] and mem_csb1[0] were low.
- **Hold.** Read bank 2 row 0x10 (preloaded 0x12345678), then 20 idle cycles with mem_dout1 driven to random values → rd_data stays 0x12345678 and rd_valid=0 throughout.
- **Collision.** Preload 0xAABBCCDD at addr 0x1_20; same-cycle read and write of 0x1_20 with data 0x11223344, mask 0b0101 → rd_data=0xAA22CC44 and coll_cnt=1.
- **Out-of-range with NUM_BANKS=3.** Write to bank 3 → no csb0 asserted. Read bank 3 → rd_valid=1, rd_data=0, addr_err=1 and stays 1.
- **Streaming reads.** Reads on 4 consecutive cycles to banks 0,1,2,3 → rd_valid high for 4 cycles and the data order matches the preloads.
- **Reset mid-read.** Assert wb_rst_ni=0 in the cycle after a read → rd_valid=0 and rd_data=0 at once, all csb bits =1, coll_cnt=0.
